// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS32 pipelined core: jump kinds decoded by the
// control unit, the bubble instruction word, and the fetch FSM state type.
package cpu_pkg;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register for the fetch stage. It catches the instruction word
// returning from memory while decode is stalled, so the word is not lost and
// does not need to be fetched again.
module fetch_hold_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_ir,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] ir,
    output logic [31:0] pc
);

    // Clear and drain both empty the entry and take priority over a new load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ir    <= NOP_WORD;
            pc    <= 32'h0000_0000;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ir    <= load_ir;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC, drives a
// one-cycle-latency instruction memory, parks a returning word in the hold
// buffer during decode stalls, and applies branch/jump redirects with a bubble.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_target,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    output logic        flush
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;

    logic        redirect;
    logic [31:0] target;

    logic [31:0] ir_d;
    logic [31:0] pc_plus4_d;
    logic        ir_valid_d;

    logic        hb_load;
    logic        hb_drain;
    logic        hb_clear;
    logic        hb_valid;
    logic [31:0] hb_ir;
    logic [31:0] hb_pc;

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hb_load),
        .drain   (hb_drain),
        .clear   (hb_clear),
        .load_ir (imem_rdata),
        .load_pc (inflight_pc_q),
        .valid   (hb_valid),
        .ir      (hb_ir),
        .pc      (hb_pc)
    );

    // Redirect selection (branch beats jr beats j) and the memory request.
    always_comb begin
        redirect = br_taken || (jump != JUMP_NONE);
        target   = pc_q;
        if (br_taken) begin
            target = br_target & 32'hFFFF_FFFC;
        end else if (jump == JUMP_JR) begin
            target = jr_target & 32'hFFFF_FFFC;
        end else if (jump == JUMP_J) begin
            target = {pc_plus4[31:28], ir[25:0], 2'b00};
        end
        imem_en   = rst_n && (redirect || !stall);
        imem_addr = redirect ? target : pc_q;
    end

    // Next FSM state, next IF/ID contents and hold-buffer control.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir;
        pc_plus4_d = pc_plus4;
        ir_valid_d = ir_valid;
        hb_load    = 1'b0;
        hb_drain   = 1'b0;
        hb_clear   = 1'b0;
        if (redirect) begin
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            hb_clear   = 1'b1;
            state_d    = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        if (inflight_q) begin
                            ir_d       = imem_rdata;
                            pc_plus4_d = inflight_pc_q + 32'd4;
                            ir_valid_d = 1'b1;
                        end else begin
                            ir_d       = NOP_WORD;
                            ir_valid_d = 1'b0;
                        end
                    end else if (inflight_q) begin
                        hb_load = 1'b1;
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        ir_d       = hb_ir;
                        pc_plus4_d = hb_pc + 32'd4;
                        ir_valid_d = hb_valid;
                        hb_drain   = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // PC, in-flight tracking, FSM state and the IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            ir            <= NOP_WORD;
            pc_plus4      <= 32'h0000_0000;
            ir_valid      <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= imem_en;
            inflight_pc_q <= imem_addr;
            if (imem_en) begin
                pc_q <= imem_addr + 32'd4;
            end
            ir       <= ir_d;
            pc_plus4 <= pc_plus4_d;
            ir_valid <= ir_valid_d;
        end
    end

    assign flush = ~ir_valid;

endmodule
